// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock, valid/ready on both sides.
// Optional DIV_ZERO_FAST_EN: a zero divisor skips RUN and goes straight to DONE.
module seq_restoring_divider #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int CNT_W = $clog2(DIVIDEND_W + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [DIVIDEND_W-1:0] dvd_q;
  logic [DIVISOR_W-1:0]  dvs_q;
  logic [DIVISOR_W:0]    rem_q;
  logic                  in_ready_q, out_valid_q, dbz_q;
  logic [DIVIDEND_W-1:0] quo_q;
  logic [DIVISOR_W-1:0]  rmd_q;

  // dvd_q doubles as the quotient register: dividend bits leave at the MSB,
  // quotient bits enter at the LSB.
  logic [DIVISOR_W:0]    rem_next, rem_d;
  logic                  take;
  logic [DIVIDEND_W-1:0] dvd_d;

  always_comb begin
    rem_next = {rem_q[DIVISOR_W-1:0], dvd_q[DIVIDEND_W-1]};
    take     = (rem_next >= {1'b0, dvs_q});
    rem_d    = take ? (rem_next - {1'b0, dvs_q}) : rem_next;
    dvd_d    = {dvd_q[DIVIDEND_W-2:0], take};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      dbz_q       <= 1'b0;
      quo_q       <= '0;
      rmd_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            dvd_q      <= dividend;
            dvs_q      <= divisor;
            rem_q      <= '0;
            cnt_q      <= CNT_W'(DIVIDEND_W);
            in_ready_q <= 1'b0;
`ifdef DIV_ZERO_FAST_EN
            if (divisor == '0) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              quo_q       <= '1;
              rmd_q       <= dividend[DIVISOR_W-1:0];
              dbz_q       <= 1'b1;
            end else begin
              state_q <= RUN;
            end
`else
            state_q <= RUN;
`endif
          end
        end
        RUN: begin
          rem_q <= rem_d;
          dvd_q <= dvd_d;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            dbz_q       <= (dvs_q == '0);
            // With a zero divisor every step subtracts 0, so the low remainder
            // bits are exactly the low dividend bits; only the quotient is forced.
            quo_q       <= (dvs_q == '0) ? '1 : dvd_d;
            rmd_q       <= rem_d[DIVISOR_W-1:0];
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign quotient    = quo_q;
  assign remainder   = rmd_q;
  assign div_by_zero = dbz_q;

endmodule
